// File: rtl/signed_divider_pkg.sv
// Shared types and constants for the 32/16 signed restoring divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state enum, operand widths, iteration count, counter width,
// overflow bounds and magnitude helpers.
package signed_divider_pkg;

  localparam int DVD_W = 32;
  localparam int DVS_W = 16;
  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER);

  // Largest quotient magnitudes representable in DVS_W bits, one per sign.
  localparam logic [DVD_W-1:0] Q_POS_MAX = DVD_W'((2 ** (DVS_W - 1)) - 1);
  localparam logic [DVD_W-1:0] Q_NEG_MAX = DVD_W'(2 ** (DVS_W - 1));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  // Magnitude of a two's complement value; the most negative input maps to
  // its unsigned magnitude (e.g. 0x80000000 stays 0x80000000).
  function automatic logic [DVD_W-1:0] abs_dvd(input logic [DVD_W-1:0] v);
    return v[DVD_W-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [DVS_W-1:0] abs_dvs(input logic [DVS_W-1:0] v);
    return v[DVS_W-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring division iteration (combinational).
// Latency: 0 cycles.
// Backpressure: none; pure function of its inputs.
// Ports: rem_in/quo_in = current partial remainder and quotient register,
// dvs = divisor magnitude, rem_out/quo_out = values after one iteration.
module div_restore_step
  import signed_divider_pkg::*;
(
  input  logic [DVS_W:0]   rem_in,
  input  logic [DVD_W-1:0] quo_in,
  input  logic [DVS_W-1:0] dvs,
  output logic [DVS_W:0]   rem_out,
  output logic [DVD_W-1:0] quo_out
);

  // One extra bit above the shifted remainder so the subtraction borrow
  // lands in a dedicated sign bit.
  logic [DVS_W+1:0] rem_sh;
  logic [DVS_W+1:0] diff;

  always_comb begin
    rem_sh = {rem_in, quo_in[DVD_W-1]};
    diff   = rem_sh - {2'b00, dvs};
    if (diff[DVS_W+1]) begin
      // Borrow: divisor did not fit, keep the shifted remainder.
      rem_out = rem_sh[DVS_W:0];
      quo_out = {quo_in[DVD_W-2:0], 1'b0};
    end else begin
      rem_out = diff[DVS_W:0];
      quo_out = {quo_in[DVD_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/signed_divider_32by16.sv
// Sequential signed 32/16 divider, restoring radix-2 on magnitudes.
// Latency: 34 edges from accept to out_valid (1 edge on divide-by-zero).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready + dividend/divisor;
// out_valid/out_ready + quotient/remainder/ovf/dbz, all registered.
module signed_divider_32by16
  import signed_divider_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DVS_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             ovf,
  output logic             dbz
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [DVD_W-1:0] quo;
  logic [DVS_W:0]   rem;
  logic [DVS_W-1:0] dvs_mag;
  logic             qsign;
  logic             dsign;

  logic [DVS_W:0]   rem_nxt;
  logic [DVD_W-1:0] quo_nxt;

  div_restore_step u_step (
    .rem_in  (rem),
    .quo_in  (quo),
    .dvs     (dvs_mag),
    .rem_out (rem_nxt),
    .quo_out (quo_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      dbz       <= 1'b0;
      cnt       <= '0;
      quo       <= '0;
      rem       <= '0;
      dvs_mag   <= '0;
      qsign     <= 1'b0;
      dsign     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            quo      <= abs_dvd(dividend);
            rem      <= '0;
            dvs_mag  <= abs_dvs(divisor);
            qsign    <= dividend[DVD_W-1] ^ divisor[DVS_W-1];
            dsign    <= dividend[DVD_W-1];
            cnt      <= '0;
            in_ready <= 1'b0;
            if (divisor == '0) begin
              quotient  <= '0;
              remainder <= '0;
              ovf       <= 1'b0;
              dbz       <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end

        CALC: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(ITER - 1)) begin
            state <= SIGN;
          end
        end

        SIGN: begin
          // The quotient magnitude limit is asymmetric: a negative result
          // may reach 2^15, a positive one only 2^15-1. The low half is
          // emitted even on overflow.
          quotient  <= DVS_W'(qsign ? (~quo + 1'b1) : quo);
          remainder <= DVS_W'(dsign ? (~rem + 1'b1) : rem);
          ovf       <= qsign ? (quo > Q_NEG_MAX) : (quo > Q_POS_MAX);
          dbz       <= 1'b0;
          out_valid <= 1'b1;
          state     <= DONE;
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_divider_32by16.sv
// Self-checking bench for signed_divider_32by16 with an expected-result queue.
// Latency: checks 34-edge normal and 1-edge divide-by-zero result timing.
// Backpressure: holds out_ready low in DONE and checks result stability.
module tb_signed_divider_32by16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        ovf;
  logic        dbz;

  signed_divider_32by16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        o;
    logic        z;
    int          lat;
    string       name;
  } exp_t;

  exp_t scb[$];
  int errors = 0;
  int checks = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits for in_ready, pushes the expectation, presents operands for exactly
  // the accept edge, then scrambles them. Returns #1 after the accept edge.
  task automatic issue(input logic [31:0] dvd, input logic [15:0] dvs,
                       input logic [15:0] q, input logic [15:0] r,
                       input logic o, input logic z, input int lat,
                       input string name);
    exp_t e;
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept: in_ready=%b required 1", name, in_ready);
    end
    e.q = q; e.r = r; e.o = o; e.z = z; e.lat = lat; e.name = name;
    scb.push_back(e);
    dividend = dvd;
    divisor  = dvs;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = 16'($urandom);
  endtask

  // Reference model: 64-bit signed arithmetic, truncating division.
  task automatic issue_model(input logic [31:0] dvd, input logic [15:0] dvs,
                             input string name);
    logic signed [31:0] sa;
    logic signed [15:0] sd;
    longint a, b, q, r;
    sa = dvd; sd = dvs;
    a = sa;   b = sd;
    if (b == 0) begin
      issue(dvd, dvs, 16'h0, 16'h0, 1'b0, 1'b1, 1, name);
    end else begin
      q = a / b;
      r = a % b;
      issue(dvd, dvs, q[15:0], r[15:0], (q > 32767) || (q < -32768), 1'b0, 34, name);
    end
  endtask

  // Scoreboard consumer: waits for out_valid, pops and compares; optionally
  // completes the handshake and checks the return to IDLE.
  task automatic collect(input bit take);
    exp_t e;
    int lat;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (scb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: result seen with no expectation queued");
      return;
    end
    e = scb.pop_front();
    if (out_valid !== 1'b1 || lat != e.lat) begin
      errors++;
      $display("FAIL %s_latency: out_valid=%b after %0d edges required 1 after %0d",
               e.name, out_valid, lat, e.lat);
    end
    checks++;
    if (quotient !== e.q) begin
      errors++;
      $display("FAIL %s_quotient: got %h required %h", e.name, quotient, e.q);
    end
    checks++;
    if (remainder !== e.r) begin
      errors++;
      $display("FAIL %s_remainder: got %h required %h", e.name, remainder, e.r);
    end
    checks++;
    if (ovf !== e.o || dbz !== e.z) begin
      errors++;
      $display("FAIL %s_flags: ovf=%b dbz=%b required ovf=%b dbz=%b",
               e.name, ovf, dbz, e.o, e.z);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy: in_ready=%b required 0 in DONE", e.name, in_ready);
    end
    if (take) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s_handshake: out_valid=%b in_ready=%b required 0 1",
                 e.name, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    checks++;
    if (quotient !== 16'h0 || remainder !== 16'h0 || ovf !== 1'b0 || dbz !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: q=%h r=%h ovf=%b dbz=%b required all 0",
               quotient, remainder, ovf, dbz);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    issue(32'h0000_0001, 16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b0, 34, "one_by_one");
    collect(1);
  endtask

  task automatic test_inverse();
    issue(32'hFFEB_3CB0, 16'hFEDC, 16'h1234, 16'h0000, 1'b0, 1'b0, 34, "booth_inv");
    collect(1);
    issue(32'hC000_8000, 16'h8000, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 34, "max_pos");
    collect(1);
  endtask

  task automatic test_signs();
    issue(32'hFFFF_FFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 34, "neg_dvd");
    collect(1);
    issue(32'h0000_0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 1'b0, 34, "neg_dvs");
    collect(1);
  endtask

  task automatic test_ovf_dbz();
    issue(32'hC000_0000, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0, 34, "ovf_pos");
    collect(1);
    issue(32'h8000_0000, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0, 34, "ovf_minint");
    collect(1);
    issue(32'hFFFF_8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0, 34, "min_q_fits");
    collect(1);
    issue(32'h1234_5678, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1, "dbz");
    collect(1);
    issue(32'h8765_4321, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1, "dbz_neg");
    collect(1);
  endtask

  task automatic test_hold();
    issue(32'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 1'b0, 34, "hold");
    collect(0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 16'd333 ||
          remainder !== 16'd1 || ovf !== 1'b0 || dbz !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable[%0d]: vld=%b rdy=%b q=%h r=%h required 1 0 014d 0001",
                 i, out_valid, in_ready, quotient, remainder);
      end
    end
    // Offer a new operand on the handshake edge; it must not be taken.
    in_valid  = 1'b1;
    dividend  = 32'd50;
    divisor   = 16'd5;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    issue(32'h1234_5678, 16'h0003, 16'h0, 16'h0, 1'b0, 1'b0, 34, "aborted");
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 16'h0 ||
        remainder !== 16'h0 || ovf !== 1'b0 || dbz !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: rdy=%b vld=%b q=%h r=%h ovf=%b dbz=%b required 1 0 0 0 0 0",
               in_ready, out_valid, quotient, remainder, ovf, dbz);
    end
    rst_n = 1'b1;
    scb.delete();
    issue(32'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, 34, "after_reset");
    collect(1);

    // Reset in DONE with out_ready high must clear the result too.
    issue_model(32'h0012_3456, 16'h1234, "reset_done");
    collect(0);
    out_ready = 1'b1;
    rst_n     = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 16'h0) begin
      errors++;
      $display("FAIL reset_done: vld=%b rdy=%b q=%h required 0 1 0000",
               out_valid, in_ready, quotient);
    end
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] a, b;
    logic signed [31:0] p;
    for (int i = 0; i < 6; i++) begin
      a = 16'($urandom);
      if (a == 0) a = 16'sd1;
      b = 16'($urandom);
      p = a * b;
      issue(p, a, b, 16'h0, 1'b0, 1'b0, 34, "product");
      collect(1);
    end
    for (int i = 0; i < 6; i++) begin
      issue_model($urandom, 16'($urandom_range(0, 65535) >> (i * 2)), "random");
      collect(1);
    end
    issue_model(32'h7FFF_FFFF, 16'h8000, "maxint_by_min");
    collect(1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_inverse();
    test_signs();
    test_ovf_dbz();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
